// File: rtl/display_scan.sv
// display_scan: time-multiplexed driver for a 3-digit 7-segment display.
// Selects one digit per slot through an external mux, decodes the returned
// BCD digit, and drives registered anode/segment lines. Each slot starts with
// a short all-dark guard, and any digit can blink for set mode.
module display_scan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] blink_mask,
  input  logic [3:0] digit_in,
  output logic [1:0] sel,
  output logic [2:0] an,
  output logic [6:0] seg
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_OFF  = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2
  } slot_t;

  slot_t         slot;
  logic [CW-1:0] cnt;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic [2:0]    an_hot;
  logic          an_lit;
  logic [2:0]    an_next;
  logic [6:0]    seg_code;
  logic [6:0]    seg_next;
  logic          slot_end;

  assign sel      = slot;
  assign slot_end = (cnt == CW'(SCAN_DIV - 1));

  // BCD to active-high 7-segment code {g,f,e,d,c,b,a}; 10..15 blank
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] code;
    code = 7'h00;
    case (d)
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

  // Next anode/segment values from the current slot state and returned digit
  always_comb begin
    an_hot   = 3'b000;
    an_lit   = 1'b0;
    an_next  = AN_OFF;
    seg_code = 7'h00;
    seg_next = SEG_OFF;

    case (slot)
      SLOT0:   an_hot = 3'b001;
      SLOT1:   an_hot = 3'b010;
      SLOT2:   an_hot = 3'b100;
      default: an_hot = 3'b000;
    endcase

    // Guard at slot start hides the one-cycle mux+decode latency
    an_lit = en && (an_hot != 3'b000) && (cnt >= CW'(BLANK_CYCLES)) &&
             !(((an_hot & blink_mask) != 3'b000) && blink_phase);

    if (an_lit) begin
      an_next = (ACTIVE_LOW != 0) ? ~an_hot : an_hot;
    end

    if (en) begin
      seg_code = decode(digit_in);
      seg_next = (ACTIVE_LOW != 0) ? ~seg_code : seg_code;
    end
  end

  // Slot ring, slot counter, frame/blink tracking and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      slot        <= SLOT0;
      cnt         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      case (slot)
        SLOT0, SLOT1, SLOT2: begin
          if (en) begin
            if (slot_end) begin
              cnt <= '0;
              case (slot)
                SLOT0: slot <= SLOT1;
                SLOT1: slot <= SLOT2;
                default: begin
                  // Wrap back to digit 0 completes one frame
                  slot <= SLOT0;
                  if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                  end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                  end
                end
              endcase
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          // Unreachable encoding: recover to digit 0
          slot <= SLOT0;
          cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed checks of display_scan with a small scan period.
module tb_display_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] blink_mask;
  logic [3:0] digit_in;
  logic [1:0] sel;
  logic [2:0] an;
  logic [6:0] seg;

  logic [3:0] mux [4];
  logic [6:0] seg_tab [16];

  int checks   = 0;
  int failures = 0;

  display_scan #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2),
    .BLINK_FRAMES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .blink_mask (blink_mask),
    .digit_in   (digit_in),
    .sel        (sel),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  // External 3:1 digit mux
  always_comb digit_in = mux[sel];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mux(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
    mux[0] = d0;
    mux[1] = d1;
    mux[2] = d2;
    mux[3] = 4'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    step();
    reset = 1'b0;
    en    = 1'b1;
  endtask

  // Expected anode after edge k (k>=1) counted from reset release
  function automatic logic [2:0] exp_an(input int k, input logic [2:0] mask);
    int p, ps, ph;
    p  = (k - 1) % 8;
    ps = ((k - 1) / 8) % 3;
    ph = ((k - 1) / 48) % 2;
    if (p >= 2 && !(mask[ps] && ph == 1))
      return ~(3'b001 << ps);
    return 3'b111;
  endfunction

  task automatic test_reset();
    set_mux(4'd5, 4'd0, 4'd9);
    blink_mask = 3'b000;
    do_reset();
    checks++;
    if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++;
    if (an !== 3'b111) begin failures++; $display("FAIL reset_an got=%b exp=111", an); end
    checks++;
    if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg); end
  endtask

  task automatic test_scan();
    int ps;
    set_mux(4'd5, 4'd0, 4'd9);
    blink_mask = 3'b000;
    do_reset();
    for (int k = 1; k <= 48; k++) begin
      step();
      ps = ((k - 1) / 8) % 3;
      checks++;
      if (sel !== 2'((k / 8) % 3)) begin
        failures++; $display("FAIL scan_sel k=%0d got=%0d exp=%0d", k, sel, (k / 8) % 3);
      end
      checks++;
      if (an !== exp_an(k, 3'b000)) begin
        failures++; $display("FAIL scan_an k=%0d got=%b exp=%b", k, an, exp_an(k, 3'b000));
      end
      checks++;
      if (seg !== seg_tab[mux[ps]]) begin
        failures++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, seg, seg_tab[mux[ps]]);
      end
    end
  endtask

  task automatic test_blank_code();
    int ps;
    set_mux(4'd5, 4'd12, 4'd9);
    blink_mask = 3'b000;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      step();
      ps = ((k - 1) / 8) % 3;
      if (ps == 1) begin
        checks++;
        if (seg !== 7'h7F) begin failures++; $display("FAIL blank_seg k=%0d got=%h exp=7f", k, seg); end
        checks++;
        if (an !== exp_an(k, 3'b000)) begin
          failures++; $display("FAIL blank_an k=%0d got=%b exp=%b", k, an, exp_an(k, 3'b000));
        end
      end
    end
  endtask

  task automatic test_blink();
    set_mux(4'd5, 4'd0, 4'd9);
    blink_mask = 3'b010;
    do_reset();
    for (int k = 1; k <= 192; k++) begin
      step();
      checks++;
      if (an !== exp_an(k, 3'b010)) begin
        failures++; $display("FAIL blink_an k=%0d got=%b exp=%b", k, an, exp_an(k, 3'b010));
      end
    end
    blink_mask = 3'b000;
  endtask

  task automatic test_en_hold();
    logic [1:0] exp_sel [4];
    logic [2:0] exp_a   [4];
    exp_sel = '{2'd1, 2'd1, 2'd2, 2'd2};
    exp_a   = '{3'b101, 3'b101, 3'b101, 3'b111};
    set_mux(4'd5, 4'd0, 4'd9);
    blink_mask = 3'b000;
    do_reset();
    repeat (13) step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (sel !== 2'd1) begin failures++; $display("FAIL hold_sel i=%0d got=%0d exp=1", i, sel); end
      checks++;
      if (an !== 3'b111) begin failures++; $display("FAIL hold_an i=%0d got=%b exp=111", i, an); end
      checks++;
      if (seg !== 7'h7F) begin failures++; $display("FAIL hold_seg i=%0d got=%h exp=7f", i, seg); end
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (sel !== exp_sel[i]) begin
        failures++; $display("FAIL resume_sel i=%0d got=%0d exp=%0d", i, sel, exp_sel[i]);
      end
      checks++;
      if (an !== exp_a[i]) begin
        failures++; $display("FAIL resume_an i=%0d got=%b exp=%b", i, an, exp_a[i]);
      end
    end
    checks++;
    if (seg !== 7'h10) begin failures++; $display("FAIL resume_seg got=%h exp=10", seg); end
  endtask

  task automatic test_reset_mid();
    set_mux(4'd5, 4'd0, 4'd9);
    blink_mask = 3'b000;
    do_reset();
    repeat (22) step();
    checks++;
    if (sel !== 2'd2) begin failures++; $display("FAIL mid_pre_sel got=%0d exp=2", sel); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (sel !== 2'd0) begin failures++; $display("FAIL mid_sel got=%0d exp=0", sel); end
    checks++;
    if (an !== 3'b111) begin failures++; $display("FAIL mid_an got=%b exp=111", an); end
    checks++;
    if (seg !== 7'h7F) begin failures++; $display("FAIL mid_seg got=%h exp=7f", seg); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (an !== ((i == 3) ? 3'b110 : 3'b111)) begin
        failures++; $display("FAIL mid_relight i=%0d got=%b exp=%b", i, an, (i == 3) ? 3'b110 : 3'b111);
      end
    end
    checks++;
    if (seg !== 7'h12) begin failures++; $display("FAIL mid_relight_seg got=%h exp=12", seg); end
  endtask

  task automatic test_decode();
    blink_mask = 3'b000;
    set_mux(4'd0, 4'd0, 4'd0);
    do_reset();
    for (int d = 0; d < 16; d++) begin
      set_mux(4'(d), 4'(d), 4'(d));
      step();
      checks++;
      if (seg !== seg_tab[d]) begin
        failures++; $display("FAIL decode d=%0d got=%h exp=%h", d, seg, seg_tab[d]);
      end
    end
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    reset      = 1'b1;
    en         = 1'b0;
    blink_mask = 3'b000;
    set_mux(4'd0, 4'd0, 4'd0);
    repeat (2) step();

    test_reset();
    test_scan();
    test_blank_code();
    test_blink();
    test_en_hold();
    test_reset_mid();
    test_decode();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
